// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle MIPS datapath
package mc_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 2-read/1-write register file, entry 0 reads as zero
module mc_regfile
    import mc_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multicycle MIPS datapath driven by the main control FSM
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        PCSrc,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic        MemtoReg,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [2:0]  ALUOp,
    input  logic        Ori,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        Zero,
    output logic [31:0] pc_q
);

    logic [31:0] pc, ir, mdr, a, b, alu_out;
    logic [31:0] rd1, rd2, imm_ext, srca, srcb, alu_result, pc_next;
    logic        pc_en;

    mc_regfile #(.NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ir[25:21]),
        .ra2   (ir[20:16]),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (RegWrite),
        .wa    (RegDst ? ir[15:11] : ir[20:16]),
        .wd    (MemtoReg ? mdr : alu_out)
    );

    assign imm_ext = Ori ? {16'b0, ir[15:0]} : sext16(ir[15:0]);
    assign srca    = ALUSrcA ? a : pc;

    always_comb begin
        srcb = b;
        case (ALUSrcB)
            SRCB_REG:    srcb = b;
            SRCB_FOUR:   srcb = 32'd4;
            SRCB_IMM:    srcb = imm_ext;
            SRCB_BRANCH: srcb = sext16(ir[15:0]) << 2;
            default:     srcb = b;
        endcase
    end

    // Ori overrides the Funct decode so the ori immediate shares the R-type class
    always_comb begin
        alu_result = srca + srcb;
        case (ALUOp)
            ALU_SUB:   alu_result = srca - srcb;
            ALU_PASSB: alu_result = srcb;
            ALU_RTYPE: begin
                if (Ori) begin
                    alu_result = srca | srcb;
                end else begin
                    case (ir[5:0])
                        F_SUB:   alu_result = srca - srcb;
                        F_AND:   alu_result = srca & srcb;
                        F_OR:    alu_result = srca | srcb;
                        F_SLT:   alu_result = ($signed(srca) < $signed(srcb)) ? 32'd1 : 32'd0;
                        default: alu_result = srca + srcb;
                    endcase
                end
            end
            default:   alu_result = srca + srcb;
        endcase
    end

    assign Zero  = (alu_result == 32'd0);
    assign pc_en = PCWrite | (PCSrc & (((ALUOp == ALU_SUB) & Zero) | (ALUOp == ALU_PASSB)));

    // PC has already been incremented by fetch when branch/jump targets are formed
    always_comb begin
        pc_next = alu_result;
        if (PCSrc && ALUOp == ALU_SUB)
            pc_next = pc + (sext16(ir[15:0]) << 2);
        else if (PCSrc && ALUOp == ALU_PASSB)
            pc_next = {pc[31:28], ir[25:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            mdr     <= mem_rdata;
            a       <= rd1;
            b       <= rd2;
            alu_out <= alu_result;
            if (pc_en)   pc <= pc_next;
            if (IRWrite) ir <= mem_rdata;
        end
    end

    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b;
    assign mem_we    = MemWrite;
    assign Opcode    = ir[31:26];
    assign Funct     = ir[5:0];
    assign pc_q      = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - self-checking bench for mc_datapath
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IorD, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg, ALUSrcA, Ori;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic [31:0] mem_rdata, mem_addr, mem_wdata, pc_q;
    logic        mem_we, Zero;
    logic [5:0]  Opcode, Funct;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_datapath #(.RESET_PC(32'h0000_0000), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Ori(Ori),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .pc_q(pc_q)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } rvec_t;

    rvec_t       rtab [9];
    logic [31:0] model_rf [32];
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IorD = 0; MemWrite = 0; IRWrite = 0; PCWrite = 0; PCSrc = 0; RegWrite = 0;
        RegDst = 0; MemtoReg = 0; ALUSrcA = 0; ALUSrcB = 2'b00; ALUOp = 3'b000; Ori = 0;
    endtask

    task automatic load_ir(input logic [31:0] w);
        idle();
        IRWrite = 1; mem_rdata = w;
        tick();
        IRWrite = 0;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({6'h23, 5'd0, r, 16'd0});
        mem_rdata = v;
        tick();
        RegDst = 0; MemtoReg = 1; RegWrite = 1;
        tick();
        idle();
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        load_ir({6'h23, 5'd0, r, 16'd0});
        tick();
        v = mem_wdata;
    endtask

    task automatic fetch(input logic [31:0] w);
        idle();
        IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; mem_rdata = w;
        tick();
        idle();
    endtask

    task automatic do_rest(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        idle(); ALUSrcB = 2'b11;
        tick();
        idle();
        case (op)
            6'h00: begin
                ALUSrcA = 1; ALUOp = 3'b010; tick(); idle();
                RegDst = 1; RegWrite = 1; tick();
            end
            6'h08: begin
                ALUSrcA = 1; ALUSrcB = 2'b10; tick(); idle();
                RegWrite = 1; tick();
            end
            6'h0D: begin
                ALUSrcA = 1; ALUSrcB = 2'b10; ALUOp = 3'b010; Ori = 1; tick(); idle();
                RegWrite = 1; tick();
            end
            6'h04: begin
                ALUSrcA = 1; ALUOp = 3'b011; PCSrc = 1; tick();
            end
            6'h02: begin
                ALUOp = 3'b100; PCSrc = 1; tick();
            end
            default: ;
        endcase
        idle();
    endtask

    task automatic exec_instr(input logic [31:0] w);
        fetch(w);
        do_rest(w);
    endtask

    task automatic set_pc(input logic [31:0] v);
        write_reg(5'd1, v);
        load_ir({6'h23, 5'd0, 5'd1, 16'd0});
        tick();
        ALUOp = 3'b100; PCWrite = 1;
        tick();
        idle();
    endtask

    // Instruction-level reference: what the architecture should do, not how
    task automatic model_exec(input logic [31:0] w);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] x, y, res, simm;
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0]; imm = w[15:0];
        x = model_rf[rs]; y = model_rf[rt];
        simm = {{16{imm[15]}}, imm};
        model_pc = model_pc + 32'd4;
        case (op)
            6'h00: begin
                case (fn)
                    6'h22:   res = x - y;
                    6'h24:   res = x & y;
                    6'h25:   res = x | y;
                    6'h2A:   res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    default: res = x + y;
                endcase
                if (rd != 0) model_rf[rd] = res;
            end
            6'h08: if (rt != 0) model_rf[rt] = x + simm;
            6'h0D: if (rt != 0) model_rf[rt] = x | {16'd0, imm};
            6'h04: if (x == y) model_pc = model_pc + (simm * 4);
            6'h02: model_pc = {model_pc[31:28], w[25:0], 2'b00};
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] w;
        logic [31:0] seeds [4];
        logic [5:0]  fl [6];

        rtab[0] = '{6'h2A, 32'd7,          32'd9,          32'd1};
        rtab[1] = '{6'h22, 32'd7,          32'd9,          32'hFFFF_FFFE};
        rtab[2] = '{6'h20, 32'hFFFF_FFFF,  32'd1,          32'd0};
        rtab[3] = '{6'h24, 32'hF0F0_00FF,  32'h0FF0_FF0F,  32'h00F0_000F};
        rtab[4] = '{6'h25, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
        rtab[5] = '{6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1};
        rtab[6] = '{6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0};
        rtab[7] = '{6'h00, 32'd3,          32'd4,          32'd7};
        rtab[8] = '{6'h2A, 32'd5,          32'd5,          32'd0};
        seeds = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
        fl    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

        idle();
        mem_rdata = 32'd0;
        rst_n = 0;
        tick(); tick();
        check("reset_pc", pc_q, 32'h0);
        check("reset_opcode", {26'd0, Opcode}, 32'h0);
        check("reset_funct", {26'd0, Funct}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_we", {31'd0, mem_we}, 32'h0);
        rst_n = 1;
        tick();

        fetch(32'h2008_0005);
        check("fetch_pc", pc_q, 32'h4);
        check("fetch_opcode", {26'd0, Opcode}, 32'h08);
        check("fetch_mem_addr", mem_addr, 32'h4);
        do_rest(32'h2008_0005);
        read_reg(5'd8, v);
        check("addi_pos", v, 32'd5);
        exec_instr(32'h2009_FFFF);
        read_reg(5'd9, v);
        check("addi_neg", v, 32'hFFFF_FFFF);

        write_reg(5'd8, 32'h0000_1000);
        exec_instr(32'h3509_8001);
        read_reg(5'd9, v);
        check("ori_zext", v, 32'h0000_9001);

        for (int i = 0; i < 9; i++) begin
            write_reg(5'd8, rtab[i].a);
            write_reg(5'd9, rtab[i].b);
            exec_instr(32'h0109_5000 | {26'd0, rtab[i].funct});
            read_reg(5'd10, v);
            check($sformatf("rtype_vec%0d", i), v, rtab[i].exp);
        end

        write_reg(5'd8, 32'h55);
        write_reg(5'd9, 32'h55);
        set_pc(32'h4);
        exec_instr(32'h1109_0003);
        check("beq_taken", pc_q, 32'h14);
        write_reg(5'd9, 32'h56);
        set_pc(32'h4);
        exec_instr(32'h1109_0003);
        check("beq_not_taken", pc_q, 32'h8);

        set_pc(32'h1000_0000);
        exec_instr(32'h0800_0040);
        check("jump", pc_q, 32'h1000_0100);

        ALUSrcB = 2'b01;
        tick();
        IorD = 1; MemWrite = 1;
        #1;
        check("iord_alu_out", mem_addr, 32'h1000_0104);
        check("mem_we_pass", {31'd0, mem_we}, 32'h1);
        idle();

        write_reg(5'd12, 32'hAAAA);
        load_ir({6'h23, 5'd0, 5'd13, 16'd0});
        mem_rdata = 32'h1234;
        tick();
        MemtoReg = 1; RegWrite = 1;
        rst_n = 0;
        #1;
        check("midop_reset_pc", pc_q, 32'h0);
        tick();
        idle();
        rst_n = 1;
        tick();
        read_reg(5'd13, v);
        check("midop_no_write", v, 32'h0);
        read_reg(5'd12, v);
        check("midop_rf_cleared", v, 32'h0);
        check("midop_pc_held", pc_q, 32'h0);

        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        model_pc = 32'd0;
        for (int r = 1; r < 8; r++) begin
            v = ($urandom_range(0, 4) == 4) ? $urandom : seeds[$urandom_range(0, 3)];
            write_reg(5'(r), v);
            model_rf[r] = v;
        end
        for (int n = 0; n < 60; n++) begin
            logic [4:0] rs, rt, rd;
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: w = {6'h00, rs, rt, rd, 5'd0, fl[$urandom_range(0, 5)]};
                1: w = {6'h08, rs, rt, 16'($urandom)};
                2: w = {6'h0D, rs, rt, 16'($urandom)};
                3: w = {6'h04, rs, rt, 16'($urandom_range(0, 15)) - 16'd8};
                default: w = {6'h02, 26'($urandom)};
            endcase
            exec_instr(w);
            model_exec(w);
            check($sformatf("rand_pc%0d", n), pc_q, model_pc);
        end
        for (int r = 0; r < 8; r++) begin
            read_reg(5'(r), v);
            check($sformatf("rand_rf%0d", r), v, model_rf[r]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
